// File: rtl/flop_fifo.sv
// flop_fifo: flip-flop based synchronous FIFO with first-word-fall-through
// head output. Sits in front of an enabled register stage whose enable is
// the same rd_en that pops this FIFO.

// One storage entry: a WIDTH-bit register loaded when its write strobe fires.
module flop_fifo_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Entry clears on reset so dout reads 0 straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (we) q <= d;
  end

endmodule

module flop_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wp, rp;
  logic                        push, pop;

  // Acceptance uses pre-edge flags; no pass-through when full or empty.
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rp];

  // Storage array: one entry per slot, written only at the write pointer.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    flop_fifo_entry #(.WIDTH(WIDTH)) u_ent (
      .clk   (clk),
      .reset (reset),
      .we    (push && (wp == AW'(g))),
      .d     (din),
      .q     (mem[g])
    );
  end

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: a rejected push or pop latches until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: doc/flop_fifo.md
# flop_fifo

Flip-flop based synchronous FIFO that buffers data words ahead of the enabled-register stages. A producer pushes words with `wr_en`. The head word is always presented on `dout`. The consumer drives `rd_en`, and the same signal serves as the `enable` of the downstream enabled register. The block absorbs bursts and back-pressure between a producer and a register stage that does not load on every clock.

## Interface
- `WIDTH`, default 32: data word width in bits.
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset. Asserting (0) clears state immediately; release is synchronous to `clk` at system level.
- `wr_en`  in  1  push request.
- `din`  in  WIDTH  push data, sampled at the `clk` rising edge when a push is accepted.
- `full`  out  1  high when count == DEPTH.
- `rd_en`  in  1  pop request; also the downstream register's enable.
- `dout`  out  WIDTH  head entry, first-word-fall-through.
- `empty`  out  1  high when count == 0.
- `count`  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- `overflow`  out  1  sticky; set by `wr_en` while `full`.
- `underflow`  out  1  sticky; set by `rd_en` while `empty`.

## Operation
- Storage: a DEPTH×WIDTH register array, write pointer `wp`, read pointer `rp`, and `count`. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with natural overflow; no comparison logic is needed for wrap.
- Push accepted = `wr_en & ~full`. On accept, `mem[wp] <= din` and `wp` advances by 1.
- Pop accepted = `rd_en & ~empty`. On accept, `rp` advances by 1. Data is not cleared.
- Acceptance uses the flag values from before the edge. There is no same-cycle pass-through:
  - Full with both requests: only the pop is accepted; the push is dropped and `overflow` is set.
  - Empty with both requests: only the push is accepted; `underflow` is set.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither. It never leaves 0..DEPTH.
- `full` and `empty` are decoded combinationally from `count`.
- `dout = mem[rp]` is combinational from registers. Its value while `empty` is the stale entry and is don't-care, except immediately after reset, when it is 0.
- `overflow` and `underflow` are sticky until reset. Rejected requests change no other state.
- Reset (`reset` = 0), applied at any time including mid-burst: `wp` = `rp` = 0, `count` = 0, all `mem` entries = 0, `overflow` = `underflow` = 0. Resulting outputs: `dout` = 0, `empty` = 1, `full` = 0. All requests are ignored while reset is held.

## Timing
- All state changes on the `clk` rising edge, or asynchronously on `reset` falling.
- Write-to-read latency is 1 cycle. A word pushed at edge N into an empty FIFO appears on `dout`, with `empty` = 0, after edge N.
- A pop at edge N presents the next entry on `dout` after edge N.
- Flags and `count` reflect the state after the most recent edge. There is no combinational path from `wr_en` or `rd_en` to any output.
- Sustained throughput is 1 push and 1 pop per cycle when 0 < count < DEPTH.
- The downstream register loads `dout` at the same edge where the pop is accepted. The consumer must gate `rd_en` with `~empty`, or tolerate loading stale data.

## Test plan
- Reset behaviour: hold `reset` = 0 with `wr_en` = 1 and `din` = 32'hDEAD for 3 cycles, then release. Required: `count` = 0, `empty` = 1, `full` = 0, `dout` = 0, both sticky flags 0.
- Fill and overflow (`DEPTH` = 4): push 1, 2, 3, 4 on consecutive cycles. Required: `count` steps 1..4, `full` = 1 after the 4th edge. Push 5 → rejected, `overflow` = 1, `count` stays 4.
- Drain, underflow and wrap: pop 4 times from the previous state. Required: `dout` shows 1, 2, 3, 4 in order, then `empty` = 1. A 5th pop sets `underflow` = 1. Then push 8'hA0..8'hA5 interleaved with pops so the pointers wrap twice. Required: strict FIFO order.
- Simultaneous push/pop: with `count` = 2, push and pop for 10 cycles. Required: `count` stays 2 and output order is preserved. At `full` with both requests: `count` becomes 3 and `overflow` = 1. At `empty` with both requests: `count` becomes 1 and `underflow` = 1.
- Downstream pairing: connect `rd_en` to a WIDTH-bit enabled register and pop only when `~empty`. Push 10, 20, 30. Required: the register `q` takes 10, 20, 30 on successive enabled edges and holds its value while `rd_en` = 0.
- Asynchronous reset mid-operation: with `count` = 3, drive `reset` low between clock edges. Required: `count` = 0, `empty` = 1 and `dout` = 0 immediately, before the next edge. After release, a push of 7 yields `dout` = 7 one edge later.
